// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares the single-port system RAM between the CPU
// (fixed priority) and a host bridge (savestate / debug). A host access
// is captured and then waits for a CPU-idle cycle. After that it owns the
// RAM for one ISSUE cycle. Its read data is captured one cycle later.
// Optional build macro RAM_ARB_STARVE_EN adds a starvation counter. The
// counter raises cpu_stall so that the host always makes progress.
module ram_access_arbiter #(
   parameter int unsigned ADDR_W       = 7,
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_en,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wren,
   input  logic [DATA_W-1:0] cpu_data,
   output logic [DATA_W-1:0] cpu_q,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_wren,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_q,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ISSUE   = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] cap_addr_q;
   logic [DATA_W-1:0] cap_data_q;
   logic              cap_wren_q;
   logic              host_own;

`ifdef RAM_ARB_STARVE_EN
   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] starve_cnt_q;
   logic             stall_q;

   // Count blocked PENDING cycles. Stall the CPU when the limit is reached.
   // Both are released at ISSUE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q <= '0;
         stall_q      <= 1'b0;
      end else if (state_q == ISSUE) begin
         starve_cnt_q <= '0;
         stall_q      <= 1'b0;
      end else if (state_q == PENDING && cpu_en && !stall_q) begin
         if (starve_cnt_q != '1) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
         end
         if (starve_cnt_q >= CNT_W'(STARVE_LIMIT - 1)) begin
            stall_q <= 1'b1;
         end
      end
   end

   assign cpu_stall = stall_q;
`else
   // The starvation limit has no effect in this build.
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
   assign cpu_stall           = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the CPU keeps the RAM until it idles or is stalled
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (host_req) state_d = PENDING;
         PENDING: if (!cpu_en || cpu_stall) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the host request at accept; later host input changes are ignored
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_addr_q <= '0;
         cap_data_q <= '0;
         cap_wren_q <= 1'b0;
      end else if (state_q == IDLE && host_req) begin
         cap_addr_q <= host_addr;
         cap_data_q <= host_data;
         cap_wren_q <= host_wren;
      end
   end

   // Host completion: pulse ack, update read data (writes leave host_q alone)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         host_ack <= 1'b0;
         host_q   <= '0;
      end else begin
         host_ack <= (state_q == CAPTURE);
         if (state_q == CAPTURE && !cap_wren_q) begin
            host_q <= ram_q;
         end
      end
   end

   // RAM port mux: the host owns the RAM only during ISSUE
   assign host_own = (state_q == ISSUE);
   assign ram_addr = host_own ? cap_addr_q : cpu_addr;
   assign ram_data = host_own ? cap_data_q : cpu_data;
   assign ram_wren = host_own ? cap_wren_q : (cpu_en & cpu_wren);

   assign cpu_q = ram_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port 128x4 system RAM between the CPU core and a host port (savestate / debug bridge).
- CPU has fixed priority. Host accesses fit into cycles where the CPU is not accessing RAM.
- A starvation counter can force a one-access CPU stall so the host always makes progress.
- Sits between the CPU core, the host bridge and the RAM. The RAM applies its own per-CPU address folding downstream.

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 4, RAM data width.
- STARVE_LIMIT, 8, consecutive blocked PENDING cycles before `cpu_stall` is raised (legal range 1-255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_en  in  1  CPU drives a RAM access this cycle.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wren  in  1  CPU write strobe (qualified by `cpu_en`).
- cpu_data  in  DATA_W  CPU write data.
- cpu_q  out  DATA_W  RAM read data to the CPU; combinational passthrough of `ram_q`.
- cpu_stall  out  1  CPU must freeze (no state advance) while high.
- host_req  in  1  host access request (level).
- host_wren  in  1  host write (1) or read (0); sampled at accept.
- host_addr  in  ADDR_W  host address; sampled at accept.
- host_data  in  DATA_W  host write data; sampled at accept.
- host_ack  out  1  one-cycle completion pulse.
- host_q  out  DATA_W  host read data; valid while `host_ack` is high and held until the next ack.
- busy  out  1  high when the arbiter is not in IDLE.
- ram_addr  out  ADDR_W  to the RAM `addr` input.
- ram_wren  out  1  to the RAM `wren` input.
- ram_data  out  DATA_W  to the RAM `data` input.
- ram_q  in  DATA_W  from the RAM `q`; registered, one cycle after the address.

Behaviour:
- Reset: the arbiter enters IDLE. `host_ack`=0, `host_q`=0, `cpu_stall`=0, starve counter=0, captured request cleared.
- RAM mux (combinational): owner is HOST only in the ISSUE state, otherwise CPU.
  - CPU owner: `ram_wren` = `cpu_en` & `cpu_wren`.
  - HOST owner: `ram_wren` = captured `host_wren`.
  - A non-enabled CPU drives `ram_wren`=0.
- States: IDLE, PENDING, ISSUE, CAPTURE.
- IDLE:
  - `host_req`=1 captures `host_addr`, `host_data` and `host_wren` into registers and moves to PENDING.
  - Otherwise stays in IDLE.
- PENDING:
  - Moves to ISSUE when `cpu_en`=0 or `cpu_stall`=1.
  - Otherwise increments the starve counter (saturating).
  - When the counter reaches STARVE_LIMIT, `cpu_stall` is registered high on the next edge.
- ISSUE:
  - Host owns RAM for exactly one cycle. A write commits at the end of this cycle.
  - While `cpu_stall`=1, any concurrent `cpu_en` is ignored (not forwarded to RAM).
  - Moves to CAPTURE.
  - Clears `cpu_stall` and the starve counter at this edge.
- CAPTURE:
  - `ram_q` holds the host read result. The CPU may own RAM this cycle.
  - At the end of the cycle: `host_q` <= `ram_q` (reads only; unchanged on writes), `host_ack` <= 1, move to IDLE.
- `host_ack` is high for exactly one cycle, coinciding with IDLE.
  - If `host_req` is still high in that cycle, a new request is accepted (back-to-back).
  - The host must drop `host_req` in the ack cycle for a single access.
- Latency: minimum accept-to-ack is 4 edges (IDLE → PENDING → ISSUE → CAPTURE → ack).
- Changes to the host inputs after accept are ignored until the next accept.
- `busy` = (state != IDLE).
- Reset mid-operation:
  - Abandons any PENDING access with no RAM write.
  - A write already committed in ISSUE stays in RAM.
  - No ack is produced for the aborted request.
- `cpu_q` after a CPU-idle cycle may carry host data; the CPU does not consume it.

Optional Feature:
- Macro: `RAM_ARB_STARVE_EN`.
- Defined: the starve counter and `cpu_stall` behave as described above.
- Undefined:
  - No counter is built and `cpu_stall` is tied to 0.
  - PENDING waits indefinitely for `cpu_en`=0; the host may never complete under continuous CPU activity.

Test Plan:
- Host read of 0x65, CPU idle: reset value 0 at 0x65, CPU writes 0xA, then `host_req`. Required: `host_ack` 4 edges after accept, `host_q`=0xA, `busy` low after ack.
- Host write 0x3 to 0x10 while the CPU reads 0x10 every cycle except one gap. Required: the write lands in the gap cycle; a later CPU read of 0x10 returns 0x3; no CPU access is corrupted.
- `cpu_en` held high continuously, STARVE_LIMIT=8, macro defined. Required: `cpu_stall` rises 8 PENDING cycles after accept; ISSUE is taken; `cpu_stall` falls after ISSUE; `host_ack` follows.
- Same stimulus with the macro undefined. Required: `cpu_stall` stays 0, `host_ack` never asserts, `busy` stays 1.
- `host_req` held high across acks for reads of 0x60, 0x61, 0x62 (host updates the address in each ack cycle). Required: three acks 4 cycles apart with the correct data in order.
- `reset_n` pulsed low during PENDING of a host write of 0xF to 0x20. Required: outputs return to reset values immediately; RAM[0x20] unchanged; no `host_ack`.
